// File: rtl/fft64_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// fft64_bitrev_reorder
//
// Converts each POINTS-sample frame coming out of fft64_streaming from
// bit-reversed bin order into natural bin order (bin 0 .. POINTS-1).
//
// Two banks of POINTS complex entries form a ping-pong buffer. The writer
// scatters each incoming sample to address bitrev(n) of the bank it owns.
// The reader drains a full bank sequentially at address 0..POINTS-1. One
// sample per clock is sustained indefinitely, and back-to-back frames drain
// with no bubble between them.
//
// Ports
//   clk        in   1       single clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   real_in    in   DATA_W  signed real part, bit-reversed order
//   imag_in    in   DATA_W  signed imaginary part
//   valid_in   in   1       input sample accepted when high
//   last_in    in   1       marks the 64th sample of a frame
//   real_out   out  DATA_W  signed real part, natural order (0 when idle)
//   imag_out   out  DATA_W  signed imaginary part, natural order (0 when idle)
//   valid_out  out  1       output beat valid
//   last_out   out  1       high with bin POINTS-1 of each output frame
//   done       out  1       one-cycle pulse coincident with last_out
//   frame_err  out  1       one-cycle pulse on a framing violation
// -----------------------------------------------------------------------------
module fft64_bitrev_reorder #(
  parameter int DATA_W = 20,
  parameter int POINTS = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] real_in,
  input  logic signed [DATA_W-1:0] imag_in,
  input  logic                     valid_in,
  input  logic                     last_in,
  output logic signed [DATA_W-1:0] real_out,
  output logic signed [DATA_W-1:0] imag_out,
  output logic                     valid_out,
  output logic                     last_out,
  output logic                     done,
  output logic                     frame_err
);

  localparam int ADDR_W = $clog2(POINTS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(POINTS - 1);

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } state_t;

  // Mirror the address bits: bit i of n lands on bit ADDR_W-1-i.
  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] n);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = n[ADDR_W-1-i];
    end
    return r;
  endfunction

  // Both banks share one array; the bank select is the address MSB.
  logic signed [DATA_W-1:0] r_mem_re [2*POINTS];
  logic signed [DATA_W-1:0] r_mem_im [2*POINTS];

  // Write-side control
  logic [ADDR_W-1:0] r_wcnt;
  logic              r_wbank;
  logic [1:0]        r_full;
  logic              r_frame_err;

  // Read-side control
  state_t            r_state;
  logic [ADDR_W-1:0] r_rcnt;
  logic              r_rbank;

  // Output register stage
  logic signed [DATA_W-1:0] r_re_p1;
  logic signed [DATA_W-1:0] r_im_p1;
  logic                     r_vld_p1;
  logic                     r_last_p1;

  logic              w_wlast;
  logic              w_wr_en;
  logic              w_frame_done;
  logic              w_frame_err;
  logic [ADDR_W:0]   w_waddr;
  logic [ADDR_W:0]   w_raddr;
  logic [1:0]        w_full_nxt;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_rcnt_nxt;
  logic              w_rbank_nxt;
  logic              w_rd_en;
  logic              w_rd_clear;
  logic              w_other_bank;

  // ---------------------------------------------------------------------------
  // Write side: frame accounting. wcnt is authoritative for frame length; an
  // early last_in aborts the partial frame and drops the offending sample.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_wlast      = (r_wcnt == LAST_IDX);
    w_frame_done = valid_in && w_wlast;
    w_frame_err  = valid_in && (last_in != w_wlast);
    w_wr_en      = valid_in && !(last_in && !w_wlast);
    w_waddr      = {r_wbank, bitrev(r_wcnt)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt      <= '0;
      r_wbank     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      if (valid_in) begin
        if (w_wlast || last_in) begin
          r_wcnt <= '0;
        end else begin
          r_wcnt <= r_wcnt + 1'b1;
        end
      end
      if (w_frame_done) begin
        r_wbank <= ~r_wbank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_re[w_waddr] <= real_in;
      r_mem_im[w_waddr] <= imag_in;
    end
  end

  // Full flags: the writer sets its bank on frame completion, the reader
  // clears its bank after the last read. They never target the same bank in
  // the same cycle because the writer never owns a full bank.
  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_clear) begin
      w_full_nxt[r_rbank] = 1'b0;
    end
    if (w_frame_done) begin
      w_full_nxt[r_wbank] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 2'b00;
    end else begin
      r_full <= w_full_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM: IDLE waits for the read bank to fill, DRAIN streams it out in
  // natural order and chains straight into the other bank if it is ready.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_rcnt_nxt   = r_rcnt;
    w_rbank_nxt  = r_rbank;
    w_rd_en      = 1'b0;
    w_rd_clear   = 1'b0;
    w_other_bank = ~r_rbank;
    unique case (r_state)
      S_IDLE: begin
        if (r_full[r_rbank]) begin
          w_state_nxt = S_DRAIN;
          w_rcnt_nxt  = '0;
        end
      end
      S_DRAIN: begin
        w_rd_en = 1'b1;
        if (r_rcnt == LAST_IDX) begin
          w_rd_clear  = 1'b1;
          w_rbank_nxt = w_other_bank;
          w_rcnt_nxt  = '0;
          if (!r_full[w_other_bank]) begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_rcnt_nxt = r_rcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_raddr = {r_rbank, r_rcnt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rcnt  <= '0;
      r_rbank <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_rbank <= w_rbank_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: registered RAM read; data is forced to zero between beats so
  // the outputs are quiet whenever valid_out is low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_re_p1   <= '0;
      r_im_p1   <= '0;
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end else begin
      r_vld_p1  <= w_rd_en;
      r_last_p1 <= w_rd_en && (r_rcnt == LAST_IDX);
      if (w_rd_en) begin
        r_re_p1 <= r_mem_re[w_raddr];
        r_im_p1 <= r_mem_im[w_raddr];
      end else begin
        r_re_p1 <= '0;
        r_im_p1 <= '0;
      end
    end
  end

  assign real_out  = r_re_p1;
  assign imag_out  = r_im_p1;
  assign valid_out = r_vld_p1;
  assign last_out  = r_last_p1;
  assign done      = r_last_p1;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_fft64_bitrev_reorder.sv
module tb_fft64_bitrev_reorder;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic signed [19:0]      real_in = '0;
  logic signed [19:0]      imag_in = '0;
  logic                    valid_in = 1'b0;
  logic                    last_in = 1'b0;
  logic signed [19:0]      real_out;
  logic signed [19:0]      imag_out;
  logic                    valid_out;
  logic                    last_out;
  logic                    done;
  logic                    frame_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;

  logic signed [19:0] q_re[$];
  logic signed [19:0] q_im[$];
  logic               q_last[$];
  logic               q_done[$];
  int                 q_cyc[$];

  fft64_bitrev_reorder #(.DATA_W(20), .POINTS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .real_in(real_in), .imag_in(imag_in),
    .valid_in(valid_in), .last_in(last_in),
    .real_out(real_out), .imag_out(imag_out),
    .valid_out(valid_out), .last_out(last_out),
    .done(done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record output beats, frame_err pulses and bank-overwrite attempts.
  always @(negedge clk) begin
    if (valid_out) begin
      q_re.push_back(real_out);
      q_im.push_back(imag_out);
      q_last.push_back(last_out);
      q_done.push_back(done);
      q_cyc.push_back(cyc);
    end
    if (frame_err) err_cnt++;
    if (rst_n && dut.w_wr_en && dut.r_full[dut.r_wbank]) ovf_cnt++;
  end

  function automatic int bitrev6(int n);
    int r;
    r = 0;
    for (int i = 0; i < 6; i++) if (n[i]) r = r | (1 << (5 - i));
    return r;
  endfunction

  task automatic send_sample(int re, int im, bit l);
    real_in  = 20'(re);
    imag_in  = 20'(im);
    valid_in = 1'b1;
    last_in  = l;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic send_frame(int base, bit gap, output int last_edge);
    for (int n = 0; n < 64; n++) begin
      send_sample(base + n, -(base + n), n == 63);
      if (n == 63) last_edge = cyc;
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_beats(int target, int budget);
    for (int i = 0; i < budget; i++) begin
      if (q_re.size() >= target) break;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (valid_out !== 1'b0) begin $display("FAIL reset_valid_out got=%b want=0", valid_out); errors++; end
    checks++; if (last_out !== 1'b0) begin $display("FAIL reset_last_out got=%b want=0", last_out); errors++; end
    checks++; if (done !== 1'b0) begin $display("FAIL reset_done got=%b want=0", done); errors++; end
    checks++; if (frame_err !== 1'b0) begin $display("FAIL reset_frame_err got=%b want=0", frame_err); errors++; end
    checks++; if (real_out !== 20'sd0) begin $display("FAIL reset_real_out got=%0d want=0", real_out); errors++; end
    checks++; if (imag_out !== 20'sd0) begin $display("FAIL reset_imag_out got=%0d want=0", imag_out); errors++; end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_frame();
    int b0, e0, le;
    logic signed [19:0] er, ei;
    b0 = q_re.size(); e0 = err_cnt;
    send_frame(0, 1'b0, le);
    wait_beats(b0 + 64, 300);
    checks++; if (q_re.size() !== b0 + 64) begin $display("FAIL single_beat_count got=%0d want=64", q_re.size() - b0); errors++; end
    if (q_re.size() >= b0 + 64) begin
      checks++; if (q_cyc[b0] !== le + 2) begin $display("FAIL single_latency got_edge=%0d want_edge=%0d", q_cyc[b0], le + 2); errors++; end
      checks++; if (q_cyc[b0+63] - q_cyc[b0] !== 63) begin $display("FAIL single_gapless span=%0d want=63", q_cyc[b0+63] - q_cyc[b0]); errors++; end
      for (int m = 0; m < 64; m++) begin
        er = 20'(bitrev6(m)); ei = 20'(-bitrev6(m));
        checks++; if (q_re[b0+m] !== er) begin $display("FAIL single_real beat=%0d got=%0d want=%0d", m, q_re[b0+m], er); errors++; end
        checks++; if (q_im[b0+m] !== ei) begin $display("FAIL single_imag beat=%0d got=%0d want=%0d", m, q_im[b0+m], ei); errors++; end
        checks++; if (q_last[b0+m] !== (m == 63)) begin $display("FAIL single_last beat=%0d got=%b", m, q_last[b0+m]); errors++; end
        checks++; if (q_done[b0+m] !== (m == 63)) begin $display("FAIL single_done beat=%0d got=%b", m, q_done[b0+m]); errors++; end
      end
    end
    checks++; if (err_cnt - e0 !== 0) begin $display("FAIL single_frame_err got=%0d want=0", err_cnt - e0); errors++; end
  endtask

  task automatic test_back_to_back();
    int b0, e0, le;
    logic signed [19:0] er, ei;
    b0 = q_re.size(); e0 = err_cnt;
    send_frame(0, 1'b0, le);
    send_frame(100, 1'b0, le);
    wait_beats(b0 + 128, 400);
    checks++; if (q_re.size() !== b0 + 128) begin $display("FAIL b2b_beat_count got=%0d want=128", q_re.size() - b0); errors++; end
    if (q_re.size() >= b0 + 128) begin
      checks++; if (q_cyc[b0+127] - q_cyc[b0] !== 127) begin $display("FAIL b2b_gapless span=%0d want=127", q_cyc[b0+127] - q_cyc[b0]); errors++; end
      checks++; if (q_re[b0+64] !== 20'sd100) begin $display("FAIL b2b_beat64 got=%0d want=100", q_re[b0+64]); errors++; end
      checks++; if (q_cyc[b0+64] !== le + 2) begin $display("FAIL b2b_latency got_edge=%0d want_edge=%0d", q_cyc[b0+64], le + 2); errors++; end
      for (int m = 0; m < 128; m++) begin
        er = 20'((m / 64) * 100 + bitrev6(m % 64));
        ei = 20'(-((m / 64) * 100 + bitrev6(m % 64)));
        checks++; if (q_re[b0+m] !== er) begin $display("FAIL b2b_real beat=%0d got=%0d want=%0d", m, q_re[b0+m], er); errors++; end
        checks++; if (q_im[b0+m] !== ei) begin $display("FAIL b2b_imag beat=%0d got=%0d want=%0d", m, q_im[b0+m], ei); errors++; end
        checks++; if (q_last[b0+m] !== (m == 63 || m == 127)) begin $display("FAIL b2b_last beat=%0d got=%b", m, q_last[b0+m]); errors++; end
      end
    end
    checks++; if (err_cnt - e0 !== 0) begin $display("FAIL b2b_frame_err got=%0d want=0", err_cnt - e0); errors++; end
  endtask

  task automatic test_gapped_input();
    int b0, le;
    logic signed [19:0] er;
    b0 = q_re.size();
    send_frame(0, 1'b1, le);
    wait_beats(b0 + 64, 300);
    checks++; if (q_re.size() !== b0 + 64) begin $display("FAIL gap_beat_count got=%0d want=64", q_re.size() - b0); errors++; end
    if (q_re.size() >= b0 + 64) begin
      checks++; if (q_cyc[b0] !== le + 2) begin $display("FAIL gap_latency got_edge=%0d want_edge=%0d", q_cyc[b0], le + 2); errors++; end
      checks++; if (q_cyc[b0+63] - q_cyc[b0] !== 63) begin $display("FAIL gap_gapless span=%0d want=63", q_cyc[b0+63] - q_cyc[b0]); errors++; end
      for (int m = 0; m < 64; m++) begin
        er = 20'(bitrev6(m));
        checks++; if (q_re[b0+m] !== er) begin $display("FAIL gap_real beat=%0d got=%0d want=%0d", m, q_re[b0+m], er); errors++; end
      end
    end
  endtask

  task automatic test_framing();
    int b0, e0, le;
    logic signed [19:0] er, ei;
    b0 = q_re.size(); e0 = err_cnt;
    for (int n = 0; n <= 10; n++) send_sample(50 + n, -(50 + n), n == 10);
    repeat (80) @(negedge clk);
    #1;
    checks++; if (err_cnt - e0 !== 1) begin $display("FAIL framing_err_pulses got=%0d want=1", err_cnt - e0); errors++; end
    checks++; if (q_re.size() !== b0) begin $display("FAIL framing_partial_out got=%0d want=0", q_re.size() - b0); errors++; end
    send_frame(200, 1'b0, le);
    wait_beats(b0 + 64, 300);
    checks++; if (q_re.size() !== b0 + 64) begin $display("FAIL framing_beat_count got=%0d want=64", q_re.size() - b0); errors++; end
    if (q_re.size() >= b0 + 64) begin
      for (int m = 0; m < 64; m++) begin
        er = 20'(200 + bitrev6(m)); ei = 20'(-(200 + bitrev6(m)));
        checks++; if (q_re[b0+m] !== er) begin $display("FAIL framing_real beat=%0d got=%0d want=%0d", m, q_re[b0+m], er); errors++; end
        checks++; if (q_im[b0+m] !== ei) begin $display("FAIL framing_imag beat=%0d got=%0d want=%0d", m, q_im[b0+m], ei); errors++; end
      end
    end
    checks++; if (err_cnt - e0 !== 1) begin $display("FAIL framing_err_total got=%0d want=1", err_cnt - e0); errors++; end
  endtask

  task automatic test_reset_mid_drain();
    int b0, le;
    logic signed [19:0] er;
    b0 = q_re.size();
    send_frame(300, 1'b0, le);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (q_re.size() >= b0 + 21) break;
    end
    checks++; if (q_re.size() !== b0 + 21) begin $display("FAIL rstmid_reach_beat20 got=%0d want=21", q_re.size() - b0); errors++; end
    if (q_re.size() >= b0 + 21) begin
      checks++; if (q_re[b0+20] !== 20'sd310) begin $display("FAIL rstmid_beat20 got=%0d want=310", q_re[b0+20]); errors++; end
    end
    rst_n = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0) begin $display("FAIL rstmid_valid_out got=%b want=0", valid_out); errors++; end
    checks++; if (real_out !== 20'sd0) begin $display("FAIL rstmid_real_out got=%0d want=0", real_out); errors++; end
    checks++; if (imag_out !== 20'sd0) begin $display("FAIL rstmid_imag_out got=%0d want=0", imag_out); errors++; end
    checks++; if (last_out !== 1'b0) begin $display("FAIL rstmid_last_out got=%b want=0", last_out); errors++; end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    checks++; if (q_re.size() !== b0 + 21) begin $display("FAIL rstmid_no_more_beats got=%0d want=21", q_re.size() - b0); errors++; end
    b0 = q_re.size();
    @(posedge clk);
    #1;
    send_frame(400, 1'b0, le);
    wait_beats(b0 + 64, 300);
    checks++; if (q_re.size() !== b0 + 64) begin $display("FAIL rstmid_next_count got=%0d want=64", q_re.size() - b0); errors++; end
    if (q_re.size() >= b0 + 64) begin
      checks++; if (q_cyc[b0] !== le + 2) begin $display("FAIL rstmid_next_latency got_edge=%0d want_edge=%0d", q_cyc[b0], le + 2); errors++; end
      for (int m = 0; m < 64; m++) begin
        er = 20'(400 + bitrev6(m));
        checks++; if (q_re[b0+m] !== er) begin $display("FAIL rstmid_next_real beat=%0d got=%0d want=%0d", m, q_re[b0+m], er); errors++; end
      end
    end
  endtask

  task automatic test_extremes();
    int b0;
    logic signed [19:0] er;
    b0 = q_re.size();
    for (int n = 0; n < 64; n++) send_sample((n % 2 == 0) ? 524287 : -524288, -524288, n == 63);
    wait_beats(b0 + 64, 300);
    checks++; if (q_re.size() !== b0 + 64) begin $display("FAIL ext_beat_count got=%0d want=64", q_re.size() - b0); errors++; end
    if (q_re.size() >= b0 + 64) begin
      for (int m = 0; m < 64; m++) begin
        er = (bitrev6(m) % 2 == 0) ? 20'sh7FFFF : 20'sh80000;
        checks++; if (q_re[b0+m] !== er) begin $display("FAIL ext_real beat=%0d got=%0d want=%0d", m, q_re[b0+m], er); errors++; end
        checks++; if (q_im[b0+m] !== 20'sh80000) begin $display("FAIL ext_imag beat=%0d got=%0d want=-524288", m, q_im[b0+m]); errors++; end
      end
    end
  endtask

  task automatic test_no_overwrite();
    checks++; if (ovf_cnt !== 0) begin $display("FAIL bank_overwrite got=%0d want=0", ovf_cnt); errors++; end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gapped_input();
    test_framing();
    test_reset_mid_drain();
    test_extremes();
    test_no_overwrite();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
